add_b_polar: RTL and testbench

- Second stage of the HDB3 encoder; sits directly downstream of the V-insertion stage and consumes its 2-bit code stream.
- Inserts the balancing B pulse wherever the count of marks since the previous V is even.
- Assigns AMI polarity and drives the bipolar line outputs data_pos/data_neg.
- Runs continuously: one code symbol per clk, no handshake.

---
 rtl/add_b_polar_if.sv | 10 +
 rtl/add_b_polar.sv | 40 ++++
 tb/tb_add_b_polar.sv | 70 +++++++
 3 files changed

// File: rtl/add_b_polar_if.sv
// add_b_polar_if: code-in / bipolar-line-out bundle of the HDB3 B-insertion and polarity stage.
interface add_b_polar_if;
  logic [1:0] datain_v;
  logic [1:0] dataout_b;
  logic       data_pos;
  logic       data_neg;
  logic       code_err;
  modport master (output datain_v, input dataout_b, data_pos, data_neg, code_err);
  modport slave  (input datain_v, output dataout_b, data_pos, data_neg, code_err);
endinterface

// File: rtl/add_b_polar.sv
// add_b_polar: HDB3 stage two, inserts balancing B pulses and assigns AMI polarity to the line.
module add_b_polar #(
  parameter bit POL_INIT = 1'b0,
  parameter bit PAR_INIT = 1'b0
) (
  input logic clk,
  input logic reset,
  add_b_polar_if.slave bus
);
  logic [3:0][1:0] sr;
  logic [1:0] din;
  logic parity, last_pol, npol;
  always_comb begin
    din = bus.datain_v == 2'b11 ? 2'b00 : bus.datain_v;
    // marks and Bs (bit 0 set) flip polarity, V repeats it, zero leaves it untouched
    npol = sr[3][0] ? ~last_pol : last_pol;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr            <= '0;
      parity        <= PAR_INIT;
      last_pol      <= POL_INIT;
      bus.dataout_b <= 2'b00;
      bus.data_pos  <= 1'b0;
      bus.data_neg  <= 1'b0;
      bus.code_err  <= 1'b0;
    end else begin
      sr[0]         <= din;
      sr[1]         <= sr[0];
      sr[2]         <= sr[1];
      sr[3]         <= (din == 2'b10 && !parity) ? 2'b11 : sr[2];
      parity        <= din == 2'b10 ? 1'b0 : din == 2'b01 ? ~parity : parity;
      last_pol      <= npol;
      bus.dataout_b <= sr[3];
      bus.data_pos  <= |sr[3] && npol;
      bus.data_neg  <= |sr[3] && !npol;
      bus.code_err  <= bus.datain_v == 2'b11;
    end
  end
endmodule

// File: tb/tb_add_b_polar.sv
// tb_add_b_polar: directed vectors against hand-computed HDB3 B-insertion and line polarity.
module tb_add_b_polar;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nv = 0;
  int errs = 0;
  add_b_polar_if bus ();
  add_b_polar dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic [1:0] d);
    bus.datain_v = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nv++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s got {b,pos,neg,err}=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(2'b00);
    chk({tag, "_rst"}, {bus.dataout_b, bus.data_pos, bus.data_neg, bus.code_err}, 5'b0);
    reset = 1'b0;
  endtask
  task automatic run(input string tag, input int n, input logic [0:7][1:0] s,
                     input logic [0:7][1:0] eb, input logic [0:7] ep, input logic [0:7] en);
    logic [1:0] d;
    logic [4:0] exp;
    for (int i = 0; i < n + 4; i++) begin
      d = 2'b00;
      if (i < n) d = s[i];
      step(d);
      exp = 5'b0;
      if (i >= 4) exp = {eb[i-4], ep[i-4], en[i-4], 1'b0};
      exp[0] = d == 2'b11;
      chk($sformatf("%s_s%0d", tag, i),
          {bus.dataout_b, bus.data_pos, bus.data_neg, bus.code_err}, exp);
    end
  endtask
  initial begin
    bus.datain_v = 2'b00;
    do_reset("odd");
    run("odd", 5, {2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 6'b0},
        {2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 6'b0}, 8'b10001000, 8'b00000000);
    do_reset("even");
    run("even", 4, {2'b00, 2'b00, 2'b00, 2'b10, 8'b0},
        {2'b11, 2'b00, 2'b00, 2'b10, 8'b0}, 8'b10010000, 8'b00000000);
    do_reset("mm");
    run("mm", 6, {2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0},
        {2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 4'b0}, 8'b10100100, 8'b01000000);
    do_reset("b2b");
    run("b2b", 8, {2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10},
        {2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10}, 8'b10010000, 8'b00001001);
    do_reset("err");
    run("err", 3, {2'b00, 2'b11, 2'b00, 10'b0}, 16'b0, 8'b0, 8'b0);
    do_reset("mid");
    step(2'b01);
    step(2'b01);
    step(2'b00);
    do_reset("mid");
    run("mid", 4, {2'b00, 2'b00, 2'b00, 2'b10, 8'b0},
        {2'b11, 2'b00, 2'b00, 2'b10, 8'b0}, 8'b10010000, 8'b00000000);
    $display("== %0d vectors applied, %0d miscompares ==", nv, errs);
    $finish;
  end
endmodule
